reg_fetch_stage: RTL and testbench

- Pipelined register-fetch stage for the next-generation core.
- Contains a parametrised 3-read/1-write register file and write-back bypass.
- Selects an immediate-extension mode per instruction.
- Captures operands into an output pipeline register under a valid/ready handshake, so it can sit between decode and execute with stalls.
- Held operands are kept coherent with later write-backs while stalled.

---
 rtl/reg_fetch_pkg.sv | 20 ++
 rtl/reg_fetch_stage_if.sv | 39 +++
 rtl/reg_fetch_stage_reg_file.sv | 40 ++++
 rtl/reg_fetch_stage.sv | 114 +++++++++++
 tb/tb_reg_fetch_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_fetch_pkg.sv
// Shared encodings and default widths for the register-fetch stage.
package reg_fetch_pkg;

    localparam int DEF_DBITS               = 32;
    localparam int DEF_REG_INDEX_BIT_WIDTH = 4;
    localparam int DEF_IMM_BITS            = 16;

    typedef enum logic [1:0] {
        IMM_SEXT  = 2'd0,
        IMM_ZEXT  = 2'd1,
        IMM_UPPER = 2'd2,
        IMM_RSVD  = 2'd3
    } imm_mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/reg_fetch_stage_if.sv
// Decode-side request, write-back port and execute-side operand bundle of the fetch stage.
interface reg_fetch_stage_if
    import reg_fetch_pkg::*;
#(
    parameter int REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_BIT_WIDTH,
    parameter int DBITS               = DEF_DBITS,
    parameter int IMM_BITS            = DEF_IMM_BITS
);
    logic                           in_valid;
    logic                           in_ready;
    logic [REG_INDEX_BIT_WIDTH-1:0] rd;
    logic [REG_INDEX_BIT_WIDTH-1:0] rs1;
    logic [REG_INDEX_BIT_WIDTH-1:0] rs2;
    logic [IMM_BITS-1:0]            imm_in;
    logic [1:0]                     imm_mode;
    logic                           wrtEn;
    logic [REG_INDEX_BIT_WIDTH-1:0] wrtIdx;
    logic [DBITS-1:0]               wrtData;
    logic                           out_valid;
    logic                           out_ready;
    logic [DBITS-1:0]               outd;
    logic [DBITS-1:0]               outReg1;
    logic [DBITS-1:0]               outReg2;
    logic [DBITS-1:0]               imm32;
    logic [REG_INDEX_BIT_WIDTH-1:0] out_rd;

    modport master (
        output in_valid, rd, rs1, rs2, imm_in, imm_mode,
        output wrtEn, wrtIdx, wrtData, out_ready,
        input  in_ready, out_valid, outd, outReg1, outReg2, imm32, out_rd
    );

    modport slave (
        input  in_valid, rd, rs1, rs2, imm_in, imm_mode,
        input  wrtEn, wrtIdx, wrtData, out_ready,
        output in_ready, out_valid, outd, outReg1, outReg2, imm32, out_rd
    );

endinterface

// File: rtl/reg_fetch_stage_reg_file.sv
// Register array with three combinational reads and one synchronous write port.
module reg_file_3r1w #(
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int DBITS               = 32,
    parameter bit ZERO_REG            = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] widx,
    input  logic [DBITS-1:0]               wdata,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] raddr_a,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] raddr_b,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] raddr_c,
    output logic [DBITS-1:0]               rdata_a,
    output logic [DBITS-1:0]               rdata_b,
    output logic [DBITS-1:0]               rdata_c
);
    localparam int NREGS = 2 ** REG_INDEX_BIT_WIDTH;

    logic [DBITS-1:0] mem [NREGS];
    logic             we_live;

    assign we_live = we && !(ZERO_REG && (widx == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we_live) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata_a = (ZERO_REG && (raddr_a == '0)) ? '0 : mem[raddr_a];
    assign rdata_b = (ZERO_REG && (raddr_b == '0)) ? '0 : mem[raddr_b];
    assign rdata_c = (ZERO_REG && (raddr_c == '0)) ? '0 : mem[raddr_c];

endmodule

// File: rtl/reg_fetch_stage.sv
// Register-fetch stage: reads operands with write-back bypass, extends the immediate and
// holds the result in a valid/ready output register that tracks write-backs while stalled.
//
// state    | meaning
// ST_EMPTY | output register holds no instruction; always ready
// ST_FULL  | output register holds an instruction waiting for execute
module reg_fetch_stage
    import reg_fetch_pkg::*;
#(
    parameter int REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_BIT_WIDTH,
    parameter int DBITS               = DEF_DBITS,
    parameter int IMM_BITS            = DEF_IMM_BITS,
    parameter bit ZERO_REG            = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    reg_fetch_stage_if.slave  bus
);
    fetch_state_e st_q, st_d;

    logic accept, xfer, stall, wr_live;
    logic [DBITS-1:0] rf_d, rf_1, rf_2;
    logic [DBITS-1:0] cap_d, cap_1, cap_2, imm_ext;
    logic [DBITS-1:0] outd_q, out1_q, out2_q, imm_q;
    logic [REG_INDEX_BIT_WIDTH-1:0] rd_q, rs1_q, rs2_q;

    reg_file_3r1w #(
        .REG_INDEX_BIT_WIDTH (REG_INDEX_BIT_WIDTH),
        .DBITS               (DBITS),
        .ZERO_REG            (ZERO_REG)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (bus.wrtEn),
        .widx    (bus.wrtIdx),
        .wdata   (bus.wrtData),
        .raddr_a (bus.rd),
        .raddr_b (bus.rs1),
        .raddr_c (bus.rs2),
        .rdata_a (rf_d),
        .rdata_b (rf_1),
        .rdata_c (rf_2)
    );

    assign bus.in_ready  = (st_q == ST_EMPTY) || bus.out_ready;
    assign bus.out_valid = (st_q == ST_FULL);
    assign accept        = bus.in_valid && bus.in_ready;
    assign xfer          = (st_q == ST_FULL) && bus.out_ready;
    assign stall         = (st_q == ST_FULL) && !bus.out_ready;

    // A write to the hardwired zero register never reaches any operand.
    assign wr_live = bus.wrtEn && !(ZERO_REG && (bus.wrtIdx == '0));

    assign cap_d = (wr_live && (bus.wrtIdx == bus.rd))  ? bus.wrtData : rf_d;
    assign cap_1 = (wr_live && (bus.wrtIdx == bus.rs1)) ? bus.wrtData : rf_1;
    assign cap_2 = (wr_live && (bus.wrtIdx == bus.rs2)) ? bus.wrtData : rf_2;

    always_comb begin
        imm_ext = DBITS'($signed(bus.imm_in));
        case (imm_mode_e'(bus.imm_mode))
            IMM_ZEXT:  imm_ext = DBITS'(bus.imm_in);
            IMM_UPPER: imm_ext = DBITS'(bus.imm_in) << (DBITS - IMM_BITS);
            default:   imm_ext = DBITS'($signed(bus.imm_in));
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q <= ST_EMPTY;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_EMPTY: if (accept) st_d = ST_FULL;
            ST_FULL:  if (xfer && !accept) st_d = ST_EMPTY;
            default:  st_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outd_q <= '0;
            out1_q <= '0;
            out2_q <= '0;
            imm_q  <= '0;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
        end else if (accept) begin
            outd_q <= cap_d;
            out1_q <= cap_1;
            out2_q <= cap_2;
            imm_q  <= imm_ext;
            rd_q   <= bus.rd;
            rs1_q  <= bus.rs1;
            rs2_q  <= bus.rs2;
        end else if (stall) begin
            if (wr_live && (bus.wrtIdx == rd_q))  outd_q <= bus.wrtData;
            if (wr_live && (bus.wrtIdx == rs1_q)) out1_q <= bus.wrtData;
            if (wr_live && (bus.wrtIdx == rs2_q)) out2_q <= bus.wrtData;
        end
    end

    assign bus.outd    = outd_q;
    assign bus.outReg1 = out1_q;
    assign bus.outReg2 = out2_q;
    assign bus.imm32   = imm_q;
    assign bus.out_rd  = rd_q;

endmodule

// File: tb/tb_reg_fetch_stage.sv
// Directed bench for reg_fetch_stage with a cycle-level reference model and literal spot checks.
module tb_reg_fetch_stage;
    import reg_fetch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_fetch_stage_if bus ();

    reg_fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural registers plus the contents of the output slot.
    logic [31:0] m_rf [16];
    logic        m_valid;
    logic [31:0] m_d, m_r1, m_r2, m_imm;
    logic [3:0]  m_rd, m_h1, m_h2;
    bit          started = 0;

    function automatic logic [31:0] rdv(input logic [3:0] i);
        if (bus.wrtEn && i != 4'd0 && bus.wrtIdx == i) return bus.wrtData;
        return m_rf[i];
    endfunction

    function automatic logic [31:0] ext(input logic [15:0] v, input logic [1:0] mode);
        if (mode == 2'd1) return {16'h0, v};
        if (mode == 2'd2) return {16'h0, v} * 32'h0001_0000;
        return v[15] ? 32'hFFFF_0000 + {16'h0, v} : {16'h0, v};
    endfunction

    always @(posedge clk) begin : model
        logic wl, acc, xfer;
        if (reset) begin
            for (int i = 0; i < 16; i++) m_rf[i] = 32'h0;
            m_valid = 1'b0;
            m_d = 0; m_r1 = 0; m_r2 = 0; m_imm = 0;
            m_rd = 0; m_h1 = 0; m_h2 = 0;
            started = 1;
        end else if (started) begin
            wl   = bus.wrtEn && (bus.wrtIdx != 4'd0);
            acc  = bus.in_valid && (!m_valid || bus.out_ready);
            xfer = m_valid && bus.out_ready;
            if (acc) begin
                m_d   = rdv(bus.rd);
                m_r1  = rdv(bus.rs1);
                m_r2  = rdv(bus.rs2);
                m_imm = ext(bus.imm_in, bus.imm_mode);
                m_rd  = bus.rd;
                m_h1  = bus.rs1;
                m_h2  = bus.rs2;
                m_valid = 1'b1;
            end else if (xfer) begin
                m_valid = 1'b0;
            end else if (m_valid) begin
                if (wl && bus.wrtIdx == m_rd) m_d  = bus.wrtData;
                if (wl && bus.wrtIdx == m_h1) m_r1 = bus.wrtData;
                if (wl && bus.wrtIdx == m_h2) m_r2 = bus.wrtData;
            end
            if (wl) m_rf[bus.wrtIdx] = bus.wrtData;
        end
    end

    always @(posedge clk) begin : compare
        #1;
        if (started) begin
            chk("out_valid", {31'h0, bus.out_valid}, {31'h0, m_valid});
            chk("in_ready",  {31'h0, bus.in_ready},  {31'h0, (!m_valid || bus.out_ready)});
            chk("outd",      bus.outd,    m_d);
            chk("outReg1",   bus.outReg1, m_r1);
            chk("outReg2",   bus.outReg2, m_r2);
            chk("imm32",     bus.imm32,   m_imm);
            chk("out_rd",    {28'h0, bus.out_rd}, {28'h0, m_rd});
        end
    end

    task automatic go();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [3:0] d, input logic [3:0] a, input logic [3:0] b,
                       input logic [15:0] imm, input logic [1:0] mode);
        bus.in_valid = 1'b1;
        bus.rd = d; bus.rs1 = a; bus.rs2 = b;
        bus.imm_in = imm; bus.imm_mode = mode;
    endtask

    task automatic wr(input logic en, input logic [3:0] idx, input logic [31:0] data);
        bus.wrtEn = en; bus.wrtIdx = idx; bus.wrtData = data;
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.rd = 0; bus.rs1 = 0; bus.rs2 = 0; bus.imm_in = 0; bus.imm_mode = 0;
        wr(1'b0, 4'd0, 32'h0);
        go();
        reset = 1'b0;
        chk("lit_reset_valid", {31'h0, bus.out_valid}, 32'h0);

        req(4'd3, 4'd5, 4'd7, 16'h0, 2'd0);
        go();
        bus.in_valid = 1'b0;
        chk("lit_rst_valid", {31'h0, bus.out_valid}, 32'h1);
        chk("lit_rst_outd",  bus.outd,    32'h0);
        chk("lit_rst_r1",    bus.outReg1, 32'h0);
        chk("lit_rst_r2",    bus.outReg2, 32'h0);
        chk("lit_rst_ready", {31'h0, bus.in_ready}, 32'h1);

        wr(1'b1, 4'd5, 32'hDEAD_BEEF);
        go();
        wr(1'b0, 4'd0, 32'h0);
        req(4'd1, 4'd5, 4'd2, 16'h8001, 2'd0);
        go();
        chk("lit_r5",    bus.outReg1, 32'hDEAD_BEEF);
        chk("lit_sext",  bus.imm32,   32'hFFFF_8001);
        bus.imm_mode = 2'd1;
        go();
        chk("lit_zext",  bus.imm32,   32'h0000_8001);
        bus.imm_mode = 2'd2;
        go();
        chk("lit_upper", bus.imm32,   32'h8001_0000);
        bus.imm_mode = 2'd3;
        go();
        chk("lit_rsvd",  bus.imm32,   32'hFFFF_8001);
        bus.in_valid = 1'b0;

        req(4'd4, 4'd4, 4'd4, 16'h0001, 2'd0);
        wr(1'b1, 4'd4, 32'h1234_5678);
        go();
        chk("lit_byp_r1", bus.outReg1, 32'h1234_5678);
        chk("lit_byp_r2", bus.outReg2, 32'h1234_5678);
        chk("lit_byp_d",  bus.outd,    32'h1234_5678);
        bus.in_valid = 1'b0;

        wr(1'b1, 4'd9, 32'h11);
        go();
        wr(1'b0, 4'd0, 32'h0);
        bus.out_ready = 1'b0;
        req(4'd1, 4'd2, 4'd9, 16'h0002, 2'd1);
        go();
        chk("lit_stall_old", bus.outReg2, 32'h11);
        req(4'd3, 4'd3, 4'd3, 16'h0003, 2'd1);
        wr(1'b1, 4'd9, 32'h99);
        go();
        chk("lit_stall_upd",   bus.outReg2, 32'h99);
        chk("lit_stall_ready", {31'h0, bus.in_ready}, 32'h0);
        wr(1'b0, 4'd0, 32'h0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        go();
        chk("lit_xfer_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("lit_xfer_keep",  bus.outReg2, 32'h99);

        wr(1'b1, 4'd0, 32'hFFFF_FFFF);
        go();
        req(4'd0, 4'd0, 4'd0, 16'h0, 2'd0);
        go();
        chk("lit_zero_r1", bus.outReg1, 32'h0);
        wr(1'b0, 4'd0, 32'h0);
        bus.in_valid = 1'b0;

        req(4'd4, 4'd5, 4'd9, 16'h7FFF, 2'd0);
        go();
        chk("lit_b2b0_valid", {31'h0, bus.out_valid}, 32'h1);
        chk("lit_b2b0_d",     bus.outd,    32'h1234_5678);
        chk("lit_b2b0_r1",    bus.outReg1, 32'hDEAD_BEEF);
        chk("lit_b2b0_r2",    bus.outReg2, 32'h99);
        req(4'd5, 4'd9, 4'd4, 16'h8000, 2'd2);
        go();
        chk("lit_b2b1_valid", {31'h0, bus.out_valid}, 32'h1);
        chk("lit_b2b1_r1",    bus.outReg1, 32'h99);
        req(4'd9, 4'd4, 4'd5, 16'h1234, 2'd1);
        reset = 1'b1;
        go();
        reset = 1'b0;
        chk("lit_b2b2_valid", {31'h0, bus.out_valid}, 32'h0);
        req(4'd4, 4'd5, 4'd9, 16'h0, 2'd0);
        go();
        chk("lit_b2b3_valid", {31'h0, bus.out_valid}, 32'h1);
        chk("lit_b2b3_d",     bus.outd,    32'h0);
        chk("lit_b2b3_r1",    bus.outReg1, 32'h0);
        chk("lit_b2b3_r2",    bus.outReg2, 32'h0);
        bus.in_valid = 1'b0;
        go();
        go();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
